sub_n_bit_serial: RTL and testbench
===================================

// Module: sub_n_bit_serial
// PURPOSE
//  Multi-cycle N-bit two's-complement subtractor: answer = input1 - input2.
//  Companion to the N-bit adder; used by the FP datapath for exponent
//  difference and mantissa subtraction where area matters more than latency.
//  Processes CHUNK bits per clock, LSB chunk first, with a borrow chain
//  registered between chunks. Uses a start / in_ready / done handshake.
// PARAMETERS
//  N      32  operand and result width in bits
//  CHUNK   8  bits per cycle; N % CHUNK == 0 required; NC = N/CHUNK chunk steps
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      reset is synchronous and active-high
//  start       in   1      request; accepted only when start && in_ready
//  input1      in   N      minuend, sampled on the accepting edge only
//  input2      in   N      subtrahend, sampled on the accepting edge only
//  in_ready    out  1      high only in IDLE
//  busy        out  1      high in RUN and DONE
//  answer      out  N      difference mod 2^N; held until the next accept
//  borrow_out  out  1      1 when input1 < input2 (unsigned); held with answer
//  done        out  1      one-cycle pulse: answer/borrow_out valid
// BEHAVIOUR
//  Reset (rst high at an edge): state=IDLE, answer=0, borrow_out=0, done=0,
//   idx=0, operand regs=0. in_ready=1, busy=0. rst overrides all, incl. mid-op.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: on accept edge (E0): latch input1/input2, carry reg=1 (no borrow),
//    idx=0, answer=0, borrow_out=0, go to RUN. start without accept = no-op.
//   RUN: each edge computes chunk idx:
//    {c,s} = a[idx] + ~b[idx] + carry (CHUNK+1 bits).
//    Write s into answer[idx*CHUNK +: CHUNK]; carry<=c; idx<=idx+1.
//    On the edge processing idx==NC-1: borrow_out<=~c, done<=1, go to DONE.
//   DONE: done high for exactly this one cycle; next edge: done<=0, go to IDLE.
//  Timing: the accept edge is E0; chunks are processed on E1..E_NC; done is
//   high during the cycle after E_NC. Accept-to-accept minimum is NC+2 edges.
//  start is ignored while busy; operand inputs are don't-care outside E0.
//  answer bits above the current chunk are 0 while in RUN; only valid when
//   done=1 and afterwards until the next accept.
//  Width: internal carry chain per chunk is CHUNK+1 bits; no overflow flag;
//   signed overflow is the caller's responsibility.
//  CHUNK==N: single RUN step, done one cycle after E1.
// TESTING
//  1 N=32,CHUNK=8: 100-58 -> answer=42, borrow_out=0, done exactly 1 cycle
//    after E4, pulse width 1.
//  2 0-1 -> answer=32'hFFFF_FFFF, borrow_out=1 (borrow ripples through all 4 chunks).
//  3 32'h8000_0000-32'h8000_0000 -> answer=0, borrow_out=0;
//    32'h0000_0100-32'h0000_00FF -> answer=1 (cross-chunk borrow).
//  4 While busy, pulse start with 7-3 -> ignored: in_ready=0, result of the
//    in-flight op unchanged, no extra done pulse.
//  5 rst high during the cycle after E2 -> next cycle: IDLE, answer=0, done=0,
//    in_ready=1; then 9-4 completes with answer=5.
//  6 CHUNK=32: 5-10 -> answer=32'hFFFF_FFFB, borrow_out=1, done high the cycle
//    after E1; back-to-back starts are accepted every 3 edges.

Source files
------------

// File: rtl/sub_n_bit_serial.sv
// Purpose : chunk-serial N-bit two's-complement subtractor, answer = input1 - input2.
// Latency : accept edge E0, chunks on E1..E_NC, done pulses the cycle after E_NC (NC+2 edges accept-to-accept).
// Backpressure: start is taken only while in_ready (IDLE); requests while busy are dropped.
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   start/in_ready       request handshake; operands sampled on the accepting edge only
//   input1, input2       minuend / subtrahend (N bits)
//   busy                 high in RUN and DONE
//   answer, borrow_out   difference mod 2^N and unsigned borrow, held until next accept
//   done                 one-cycle pulse marking answer/borrow_out valid
module sub_n_bit_serial #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         in_ready,
    output logic         busy,
    output logic [N-1:0] answer,
    output logic         borrow_out,
    output logic         done
);

    localparam int NC = N / CHUNK;
    // Keep the index at least one bit wide so CHUNK == N still elaborates.
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0] minuend;
        logic [N-1:0] subtrahend;
    } operands_t;

    state_t      state;
    operands_t   ops;
    logic        carry;
    logic [IW-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_carry;

    // Subtraction as a + ~b + carry; carry into chunk 0 is 1 (the +1 of
    // the two's complement), so a carry-out of 0 means a borrow.
    assign a_chunk = ops.minuend[idx*CHUNK +: CHUNK];
    assign b_chunk = ops.subtrahend[idx*CHUNK +: CHUNK];
    assign {chunk_carry, chunk_sum} = {1'b0, a_chunk}
                                    + {1'b0, ~b_chunk}
                                    + {{CHUNK{1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ops        <= '0;
            carry      <= 1'b1;
            idx        <= '0;
            answer     <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ops.minuend    <= input1;
                        ops.subtrahend <= input2;
                        carry          <= 1'b1;
                        idx            <= '0;
                        answer         <= '0;
                        borrow_out     <= 1'b0;
                        state          <= RUN;
                        in_ready       <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                RUN: begin
                    answer[idx*CHUNK +: CHUNK] <= chunk_sum;
                    carry                      <= chunk_carry;
                    if (idx == LAST_IDX) begin
                        borrow_out <= ~chunk_carry;
                        done       <= 1'b1;
                        idx        <= '0;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    done     <= 1'b0;
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_n_bit_serial.sv
module tb_sub_n_bit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // CHUNK=8 instance
    logic        start8;
    logic [31:0] in1_8, in2_8;
    logic        in_ready8, busy8, borrow8, done8;
    logic [31:0] answer8;
    // CHUNK=32 instance
    logic        start32;
    logic [31:0] in1_32, in2_32;
    logic        in_ready32, busy32, borrow32, done32;
    logic [31:0] answer32;

    sub_n_bit_serial #(.N(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .input1(in1_8), .input2(in2_8),
        .in_ready(in_ready8), .busy(busy8), .answer(answer8),
        .borrow_out(borrow8), .done(done8)
    );

    sub_n_bit_serial #(.N(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .input1(in1_32), .input2(in2_32),
        .in_ready(in_ready32), .busy(busy32), .answer(answer32),
        .borrow_out(borrow32), .done(done32)
    );

    typedef struct {
        logic [31:0] ans;
        logic        bo;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitors: pop an expectation whenever done is seen, and enforce a one-cycle pulse.
    logic prev_done8 = 1'b0;
    logic prev_done32 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_done8) check("done8_width", {31'd0, done8}, 32'd0);
        if (done8) begin
            if (q8.size() == 0) begin
                fail_now("done8_unexpected");
            end else begin
                e = q8.pop_front();
                check("answer8", answer8, e.ans);
                check("borrow8", {31'd0, borrow8}, {31'd0, e.bo});
                check("done8_cycle", cyc, e.due);
            end
        end
        prev_done8 = done8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (prev_done32) check("done32_width", {31'd0, done32}, 32'd0);
        if (done32) begin
            if (q32.size() == 0) begin
                fail_now("done32_unexpected");
            end else begin
                e = q32.pop_front();
                check("answer32", answer32, e.ans);
                check("borrow32", {31'd0, borrow32}, {31'd0, e.bo});
                check("done32_cycle", cyc, e.due);
            end
        end
        prev_done32 = done32;
    end

    // Called at a negedge; returns at the negedge following the accept edge E0.
    task automatic issue(input bit wide, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ea, input logic eb, output int e0);
        int guard = 0;
        while (!(wide ? in_ready32 : in_ready8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) fail_now("issue_wait_in_ready_timeout");
        if (wide) begin
            start32 = 1'b1; in1_32 = a; in2_32 = b;
        end else begin
            start8 = 1'b1; in1_8 = a; in2_8 = b;
        end
        @(negedge clk);
        e0 = cyc;
        if (wide) begin
            start32 = 1'b0; in1_32 = 32'hDEAD_BEEF; in2_32 = 32'hCAFE_F00D;
            q32.push_back('{ans: ea, bo: eb, due: e0 + 1});
        end else begin
            start8 = 1'b0; in1_8 = 32'hDEAD_BEEF; in2_8 = 32'hCAFE_F00D;
            q8.push_back('{ans: ea, bo: eb, due: e0 + 4});
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!(in_ready8 && in_ready32) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) fail_now("wait_idle_timeout");
    endtask

    // Directed vectors for the CHUNK=8 instance (expected values hand-computed).
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ans;
        logic        bo;
    } vec_t;

    vec_t vecs8[4];
    vec_t vecs32[3];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int e0_prev;

        vecs8[0] = '{32'd100,         32'd58,          32'd42,          1'b0};
        vecs8[1] = '{32'd0,           32'd1,           32'hFFFF_FFFF,   1'b1};
        vecs8[2] = '{32'h8000_0000,   32'h8000_0000,   32'h0000_0000,   1'b0};
        vecs8[3] = '{32'h0000_0100,   32'h0000_00FF,   32'h0000_0001,   1'b0};

        vecs32[0] = '{32'd5,          32'd10,          32'hFFFF_FFFB,   1'b1};
        vecs32[1] = '{32'hFFFF_FFFF,  32'd1,           32'hFFFF_FFFE,   1'b0};
        vecs32[2] = '{32'd0,          32'h8000_0000,   32'h8000_0000,   1'b1};

        rst = 1'b1;
        start8 = 1'b0; in1_8 = '0; in2_8 = '0;
        start32 = 1'b0; in1_32 = '0; in2_32 = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_in_ready8", {31'd0, in_ready8}, 32'd1);
        check("rst_busy8",     {31'd0, busy8},     32'd0);
        check("rst_answer8",   answer8,            32'd0);
        check("rst_borrow8",   {31'd0, borrow8},   32'd0);
        check("rst_done8",     {31'd0, done8},     32'd0);
        check("rst_in_ready32", {31'd0, in_ready32}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic vector, then 0-1: after E1 only the low chunk is written
        issue(1'b0, vecs8[0].a, vecs8[0].b, vecs8[0].ans, vecs8[0].bo, e0);
        wait_idle();
        issue(1'b0, vecs8[1].a, vecs8[1].b, vecs8[1].ans, vecs8[1].bo, e0);
        @(negedge clk);
        check("run_upper_zero8", answer8, 32'h0000_00FF);
        check("run_busy8", {31'd0, busy8}, 32'd1);
        wait_idle();
        issue(1'b0, vecs8[2].a, vecs8[2].b, vecs8[2].ans, vecs8[2].bo, e0);
        wait_idle();
        issue(1'b0, vecs8[3].a, vecs8[3].b, vecs8[3].ans, vecs8[3].bo, e0);
        wait_idle();

        // start while busy is dropped: no extra done, result untouched
        issue(1'b0, 32'h1234_5678, 32'h0000_1000, 32'h1234_4678, 1'b0, e0);
        @(negedge clk);
        check("busy_in_ready8", {31'd0, in_ready8}, 32'd0);
        start8 = 1'b1; in1_8 = 32'd7; in2_8 = 32'd3;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("held_answer8", answer8, 32'h1234_4678);

        // Reset mid-operation (high during the cycle after E2)
        issue(1'b0, 32'hAAAA_5555, 32'h1111_2222, 32'h9999_3333, 1'b0, e0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(q8.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready8", {31'd0, in_ready8}, 32'd1);
        check("abort_answer8",   answer8,            32'd0);
        check("abort_done8",     {31'd0, done8},     32'd0);
        check("abort_busy8",     {31'd0, busy8},     32'd0);
        issue(1'b0, 32'd9, 32'd4, 32'd5, 1'b0, e0);
        wait_idle();

        // CHUNK=N instance: back-to-back accepts every 3 edges
        issue(1'b1, vecs32[0].a, vecs32[0].b, vecs32[0].ans, vecs32[0].bo, e0);
        for (int i = 1; i < 3; i++) begin
            e0_prev = e0;
            issue(1'b1, vecs32[i].a, vecs32[i].b, vecs32[i].ans, vecs32[i].bo, e0);
            check("b2b_spacing32", e0 - e0_prev, 32'd3);
        end
        wait_idle();
        repeat (4) @(negedge clk);

        check("q8_drained",  q8.size(),  32'd0);
        check("q32_drained", q32.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
